pc_branch_unit: RTL and testbench

//  Program-counter stage driven by the CPU controller's PC control outputs. Holds the
//  16-bit PC (instruction-memory fetch address), evaluates branch/jump conditions against
//  PSR flags, applies signed displacements or absolute jump targets, and produces the

---
 rtl/pc_branch_unit_if.sv | 43 ++++
 rtl/pc_branch_unit.sv | 159 +++++++++++++++
 tb/tb_pc_branch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pc_branch_unit_if.sv
// PC-stage bundle between the CPU controller (master) and pc_branch_unit (slave).
// The call/return signals exist only when PC_RAS_EN is defined.
interface pc_branch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              PCReset;
   logic              PCIncrement;
   logic              PCWrite;
   logic              Branch;
   logic [3:0]        Cond;
   logic [4:0]        PSR;
   logic [7:0]        PCImmediate;
   logic [ADDR_W-1:0] JumpTarget;
   logic [ADDR_W-1:0] PC;
   logic [ADDR_W-1:0] Link;
   logic              Taken;
`ifdef PC_RAS_EN
   logic              Call;
   logic              Ret;
   logic              RasOverflow;
   logic              RasUnderflow;

   modport master (
      output PCReset, PCIncrement, PCWrite, Branch, Cond, PSR, PCImmediate, JumpTarget,
             Call, Ret,
      input  PC, Link, Taken, RasOverflow, RasUnderflow
   );
   modport slave (
      input  PCReset, PCIncrement, PCWrite, Branch, Cond, PSR, PCImmediate, JumpTarget,
             Call, Ret,
      output PC, Link, Taken, RasOverflow, RasUnderflow
   );
`else
   modport master (
      output PCReset, PCIncrement, PCWrite, Branch, Cond, PSR, PCImmediate, JumpTarget,
      input  PC, Link, Taken
   );
   modport slave (
      input  PCReset, PCIncrement, PCWrite, Branch, Cond, PSR, PCImmediate, JumpTarget,
      output PC, Link, Taken
   );
`endif
endinterface

// File: rtl/pc_branch_unit.sv
// Program-counter stage: conditional branches, absolute jumps and JAL link value.
// Define PC_RAS_EN to add a circular return-address stack driven by Call/Ret.
module pc_branch_unit #(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input logic             Clock,
   input logic             Reset,
   pc_branch_unit_if.slave bus
);

   if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RAS_DEPTH must be a power of 2 and at least 2");
   end

   logic              cond_true;
   logic              ok;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] imm_ext;
   logic              taken_q, taken_d;

   logic c_f, l_f, f_f, z_f, n_f;
   assign {c_f, l_f, f_f, z_f, n_f} = bus.PSR;

   always_comb begin
      cond_true = 1'b0;
      case (bus.Cond)
         4'h0: cond_true = z_f;
         4'h1: cond_true = ~z_f;
         4'h2: cond_true = c_f;
         4'h3: cond_true = ~c_f;
         4'h4: cond_true = l_f;
         4'h5: cond_true = ~l_f;
         4'h6: cond_true = n_f;
         4'h7: cond_true = ~n_f;
         4'h8: cond_true = f_f;
         4'h9: cond_true = ~f_f;
         4'hA: cond_true = ~l_f & ~z_f;
         4'hB: cond_true = l_f | z_f;
         4'hC: cond_true = ~n_f & ~z_f;
         4'hD: cond_true = n_f | z_f;
         4'hE: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   assign ok      = ~bus.Branch | cond_true;
   assign pc_inc  = pc_q + ADDR_W'(1);
   assign imm_ext = {{(ADDR_W-8){bus.PCImmediate[7]}}, bus.PCImmediate};

`ifdef PC_RAS_EN
   localparam int unsigned    PTR_W    = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W:0]    count_q;
   logic              ovf_q, unf_q;
   logic              push, pop, unf_set;
   logic [ADDR_W-1:0] ras_top;

   assign ras_top = ras_q[ptr_q - PTR_W'(1)];
`endif

   always_comb begin
      pc_d    = pc_q;
      taken_d = 1'b0;
      if (bus.PCWrite) begin
         if (ok) begin
            pc_d    = bus.JumpTarget;
            taken_d = 1'b1;
         end else begin
            pc_d = pc_inc;
         end
      end else if (bus.PCIncrement) begin
         if (ok) begin
            pc_d    = pc_q + imm_ext;
            taken_d = bus.Branch;
         end else begin
            pc_d = pc_inc;
         end
      end
`ifdef PC_RAS_EN
      push    = bus.PCWrite & ok & bus.Call & ~bus.Ret;
      pop     = 1'b0;
      unf_set = 1'b0;
      // Conflicting Call+Ret degrades to a plain sequential step
      if (bus.Call & bus.Ret) begin
         if (bus.PCWrite | bus.PCIncrement) begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
         end
      end else if (!bus.PCWrite && bus.PCIncrement && bus.Ret) begin
         if (count_q != '0) begin
            pc_d    = ras_top;
            taken_d = 1'b1;
            pop     = 1'b1;
         end else begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
            unf_set = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pc_q    <= RESET_VEC;
         taken_q <= 1'b0;
`ifdef PC_RAS_EN
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
`endif
      end else if (!bus.PCReset) begin
         pc_q    <= RESET_VEC;
         taken_q <= 1'b0;
`ifdef PC_RAS_EN
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
`endif
      end else begin
         pc_q    <= pc_d;
         taken_q <= taken_d;
`ifdef PC_RAS_EN
         // When full, the pointer wraps onto the oldest entry and overwrites it
         if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (count_q == RAS_FULL) ovf_q <= 1'b1;
            else count_q <= count_q + (PTR_W+1)'(1);
         end else if (pop) begin
            ptr_q   <= ptr_q - PTR_W'(1);
            count_q <= count_q - (PTR_W+1)'(1);
         end
         if (unf_set) unf_q <= 1'b1;
`endif
      end
   end

`ifdef PC_RAS_EN
   always_ff @(posedge Clock) begin
      if (push) ras_q[ptr_q] <= pc_inc;
   end

   assign bus.RasOverflow  = ovf_q;
   assign bus.RasUnderflow = unf_q;
`endif

   assign bus.PC    = pc_q;
   assign bus.Link  = pc_inc;
   assign bus.Taken = taken_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; the return-stack section runs when PC_RAS_EN is defined.
module tb_pc_branch_unit;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   pc_branch_unit_if #(.ADDR_W(16)) bus ();

   pc_branch_unit #(
      .ADDR_W   (16),
      .RESET_VEC(16'h0000),
      .RAS_DEPTH(4)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Present one cycle of controller outputs, clock it in, then drop the strobes
   task automatic apply(input logic w, input logic i, input logic b, input logic [3:0] c,
                        input logic [4:0] p, input logic [7:0] imm, input logic [15:0] jt);
      bus.PCWrite     = w;
      bus.PCIncrement = i;
      bus.Branch      = b;
      bus.Cond        = c;
      bus.PSR         = p;
      bus.PCImmediate = imm;
      bus.JumpTarget  = jt;
      step();
      bus.PCWrite     = 1'b0;
      bus.PCIncrement = 1'b0;
      bus.Branch      = 1'b0;
   endtask

   // {cond, psr{C,L,F,Z,N}, expected cond_true}
   localparam logic [9:0] VEC [16] = '{
      {4'h2, 5'b10000, 1'b1}, {4'h3, 5'b10000, 1'b0}, {4'h4, 5'b01000, 1'b1},
      {4'h5, 5'b01000, 1'b0}, {4'h6, 5'b00001, 1'b1}, {4'h7, 5'b00000, 1'b1},
      {4'h8, 5'b00100, 1'b1}, {4'h9, 5'b00100, 1'b0}, {4'hA, 5'b00000, 1'b1},
      {4'hA, 5'b00010, 1'b0}, {4'hB, 5'b00010, 1'b1}, {4'hB, 5'b00000, 1'b0},
      {4'hC, 5'b00000, 1'b1}, {4'hC, 5'b00001, 1'b0}, {4'hD, 5'b00001, 1'b1},
      {4'h1, 5'b00010, 1'b0}
   };

   initial begin
      logic [9:0] v;
      bus.PCReset     = 1'b1;
      bus.PCWrite     = 1'b0;
      bus.PCIncrement = 1'b0;
      bus.Branch      = 1'b0;
      bus.Cond        = 4'h0;
      bus.PSR         = 5'b0;
      bus.PCImmediate = 8'h01;
      bus.JumpTarget  = 16'h0;
`ifdef PC_RAS_EN
      bus.Call = 1'b0;
      bus.Ret  = 1'b0;
`endif
      #2;
      check("reset_pc", 32'(bus.PC), 32'h0000);
      check("reset_taken", 32'(bus.Taken), 32'h0);
      check("reset_link", 32'(bus.Link), 32'h0001);
      #1 Reset = 1'b1;

      for (int k = 1; k <= 3; k++) begin
         apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'h01, 16'h0);
         check($sformatf("seq_pc%0d", k), 32'(bus.PC), 32'(k));
         check($sformatf("seq_taken%0d", k), 32'(bus.Taken), 32'h0);
      end

      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0010);
      check("jmp_pc", 32'(bus.PC), 32'h0010);
      check("jmp_taken", 32'(bus.Taken), 32'h1);
      apply(1'b0, 1'b1, 1'b1, 4'h0, 5'b00010, 8'hF0, 16'h0);
      check("beq_taken_pc", 32'(bus.PC), 32'h0000);
      check("beq_taken", 32'(bus.Taken), 32'h1);
      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0010);
      apply(1'b0, 1'b1, 1'b1, 4'h0, 5'b00000, 8'hF0, 16'h0);
      check("beq_nt_pc", 32'(bus.PC), 32'h0011);
      check("beq_nt_taken", 32'(bus.Taken), 32'h0);

      apply(1'b1, 1'b1, 1'b1, 4'hE, 5'b0, 8'h05, 16'h1234);
      check("uc_jmp_pc", 32'(bus.PC), 32'h1234);
      check("uc_jmp_taken", 32'(bus.Taken), 32'h1);
      apply(1'b1, 1'b1, 1'b1, 4'hF, 5'b11111, 8'h05, 16'h4321);
      check("never_pc", 32'(bus.PC), 32'h1235);
      check("never_taken", 32'(bus.Taken), 32'h0);
      check("never_link", 32'(bus.Link), 32'h1236);
      apply(1'b0, 1'b0, 1'b1, 4'hE, 5'b0, 8'h05, 16'h4321);
      check("hold_pc", 32'(bus.PC), 32'h1235);
      check("hold_taken", 32'(bus.Taken), 32'h0);

      for (int k = 0; k < 16; k++) begin
         v = VEC[k];
         apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0100);
         apply(1'b0, 1'b1, 1'b1, v[9:6], v[5:1], 8'h08, 16'h0);
         check($sformatf("cond%0d_%h_pc", k, v[9:6]), 32'(bus.PC), v[0] ? 32'h0108 : 32'h0101);
         check($sformatf("cond%0d_%h_taken", k, v[9:6]), 32'(bus.Taken), 32'(v[0]));
      end

      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0100);
      apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'h80, 16'h0);
      check("neg_disp_pc", 32'(bus.PC), 32'h0080);

      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'hFFFF);
      apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'h01, 16'h0);
      check("wrap_up_pc", 32'(bus.PC), 32'h0000);
      apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'hFF, 16'h0);
      check("wrap_down_pc", 32'(bus.PC), 32'hFFFF);

      bus.PCReset = 1'b0;
      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h1234);
      bus.PCReset = 1'b1;
      check("pcreset_pc", 32'(bus.PC), 32'h0000);
      check("pcreset_taken", 32'(bus.Taken), 32'h0);

      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0042);
      check("pre_async_pc", 32'(bus.PC), 32'h0042);
      #2 Reset = 1'b0;
      #1;
      check("async_pc", 32'(bus.PC), 32'h0000);
      check("async_taken", 32'(bus.Taken), 32'h0);
      #1 Reset = 1'b1;

`ifdef PC_RAS_EN
      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0010);
      for (int k = 0; k < 5; k++) begin
         bus.Call = 1'b1;
         apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'(16'h0100 * (k + 1)));
         bus.Call = 1'b0;
      end
      check("ras_call_pc", 32'(bus.PC), 32'h0500);
      check("ras_ovf", 32'(bus.RasOverflow), 32'h1);
      for (int k = 0; k < 4; k++) begin
         bus.Ret = 1'b1;
         apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'h01, 16'h0);
         bus.Ret = 1'b0;
         check($sformatf("ras_ret%0d_pc", k), 32'(bus.PC), 32'(16'h0100 * (4 - k) + 16'h1));
         check($sformatf("ras_ret%0d_taken", k), 32'(bus.Taken), 32'h1);
      end
      check("ras_unf_pre", 32'(bus.RasUnderflow), 32'h0);
      bus.Ret = 1'b1;
      apply(1'b0, 1'b1, 1'b0, 4'h0, 5'b0, 8'h01, 16'h0);
      bus.Ret = 1'b0;
      check("ras_empty_pc", 32'(bus.PC), 32'h0102);
      check("ras_empty_taken", 32'(bus.Taken), 32'h0);
      check("ras_unf", 32'(bus.RasUnderflow), 32'h1);
      check("ras_ovf_sticky", 32'(bus.RasOverflow), 32'h1);
      bus.Call = 1'b1;
      bus.Ret  = 1'b1;
      apply(1'b1, 1'b0, 1'b0, 4'h0, 5'b0, 8'h00, 16'h0777);
      bus.Call = 1'b0;
      bus.Ret  = 1'b0;
      check("ras_callret_pc", 32'(bus.PC), 32'h0103);
      check("ras_callret_taken", 32'(bus.Taken), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
